// File: rtl/syn_lb_master.sv
// syn_lb_master
// Local-bus initiator for the Synesthesia register blocks. It accepts one
// register request at a time on a valid/ready command port, turns it into a
// single-cycle lb write or read strobe and returns exactly one response pulse.
// Reads are bounded by a timeout. Read-valid pulses seen outside the read
// window are counted in a saturating stray counter.
//
// Ports:
//   sys_clk_50              clock, rising edge
//   sys_rst                 asynchronous reset, active low
//   req_valid/req_ready     command handshake
//   req_wr/req_addr/req_data  captured request (1 = write)
//   rsp_valid/rsp_err/rsp_data  one-cycle response; err = read timeout
//   lb_wr_en/lb_rd_en       one-cycle local-bus strobes
//   lb_addr/lb_wr_data      local-bus address and write data
//   lb_rd_valid/lb_rd_data  slave read return
//   stray_cnt               saturating count of out-of-window read-valids
module syn_lb_master #(
    parameter int          LB_DATA_W = 32,
    parameter int          LB_ADDR_W = 12,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                 sys_clk_50,
    input  logic                 sys_rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [LB_ADDR_W-1:0] req_addr,
    input  logic [LB_DATA_W-1:0] req_data,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [LB_DATA_W-1:0] rsp_data,
    output logic                 lb_wr_en,
    output logic                 lb_rd_en,
    output logic [LB_ADDR_W-1:0] lb_addr,
    output logic [LB_DATA_W-1:0] lb_wr_data,
    input  logic                 lb_rd_valid,
    input  logic [LB_DATA_W-1:0] lb_rd_data,
    output logic [7:0]           stray_cnt
);

    localparam int                   CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [LB_DATA_W-1:0] ERR_VAL  = LB_DATA_W'(ERR_DATA);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        RSP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             hs;
    logic             timed_out;

    assign hs        = req_valid & req_ready;
    assign timed_out = (cnt == CNT_LAST);

    always_ff @(posedge sys_clk_50 or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_nx = req_wr ? WR : RD;
                end
            end
            WR:      state_nx = RSP;
            RD:      state_nx = RD_WAIT;
            RD_WAIT: begin
                if (lb_rd_valid || timed_out) begin
                    state_nx = RSP;
                end
            end
            RSP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes and handshake outputs are decoded from the next state so that
    // they are registered yet still line up with the state they belong to.
    always_ff @(posedge sys_clk_50 or negedge sys_rst) begin
        if (!sys_rst) begin
            req_ready  <= 1'b0;
            lb_wr_en   <= 1'b0;
            lb_rd_en   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_data   <= '0;
            lb_addr    <= '0;
            lb_wr_data <= '0;
            cnt        <= '0;
            stray_cnt  <= '0;
        end else begin
            req_ready <= (state_nx == IDLE);
            lb_wr_en  <= (state_nx == WR);
            lb_rd_en  <= (state_nx == RD);
            rsp_valid <= (state_nx == RSP);

            if (hs) begin
                lb_addr <= req_addr;
                if (req_wr) begin
                    lb_wr_data <= req_data;
                end
            end

            if (state == RD) begin
                cnt <= '0;
            end else if (state == RD_WAIT) begin
                cnt <= cnt + 1'b1;
            end

            if (state == WR) begin
                rsp_err  <= 1'b0;
                rsp_data <= '0;
            end else if (state == RD_WAIT) begin
                // A valid in the final wait cycle still beats the timeout.
                if (lb_rd_valid) begin
                    rsp_err  <= 1'b0;
                    rsp_data <= lb_rd_data;
                end else if (timed_out) begin
                    rsp_err  <= 1'b1;
                    rsp_data <= ERR_VAL;
                end
            end

            if (lb_rd_valid && (state != RD_WAIT) && (stray_cnt != 8'hFF)) begin
                stray_cnt <= stray_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_syn_lb_master.sv
// Self-checking bench for syn_lb_master: expected responses are queued when a
// request is issued and compared when rsp_valid appears.
module tb_syn_lb_master;

    localparam int DW      = 32;
    localparam int AW      = 12;
    localparam int TO      = 16;

    logic          clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_data;
    logic          lb_wr_en;
    logic          lb_rd_en;
    logic [AW-1:0] lb_addr;
    logic [DW-1:0] lb_wr_data;
    logic          lb_rd_valid = 1'b0;
    logic [DW-1:0] lb_rd_data = '0;
    logic [7:0]    stray_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;

    syn_lb_master #(
        .LB_DATA_W(DW),
        .LB_ADDR_W(AW),
        .TIMEOUT  (TO),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .sys_clk_50 (clk),
        .sys_rst    (sys_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_data   (rsp_data),
        .lb_wr_en   (lb_wr_en),
        .lb_rd_en   (lb_rd_en),
        .lb_addr    (lb_addr),
        .lb_wr_data (lb_wr_data),
        .lb_rd_valid(lb_rd_valid),
        .lb_rd_data (lb_rd_data),
        .stray_cnt  (stray_cnt)
    );

    always #5 clk = ~clk;

    // Response scoreboard and strobe exclusivity, sampled mid-cycle.
    always @(negedge clk) begin
        if (sys_rst) begin
            checks++;
            if (lb_wr_en && lb_rd_en) begin
                errors++;
                $display("FAIL strobe_excl: wr_en=%b rd_en=%b, required not both 1", lb_wr_en, lb_rd_en);
            end
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got err=%b data=%h, required no response", rsp_err, rsp_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({rsp_err, rsp_data} !== {mon_e.err, mon_e.data}) begin
                        errors++;
                        $display("FAIL rsp_payload: got err=%b data=%h, required err=%b data=%h",
                                 rsp_err, rsp_data, mon_e.err, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL wait_ready: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, lb_wr_en, lb_rd_en} !== 5'b0 ||
            rsp_data !== '0 || lb_addr !== '0 || lb_wr_data !== '0 || stray_cnt !== 8'd0) begin
            errors++;
            $display("FAIL %s: rdy=%b rv=%b re=%b we=%b rde=%b rd=%h a=%h wd=%h sc=%0d, required all 0",
                     name, req_ready, rsp_valid, rsp_err, lb_wr_en, lb_rd_en,
                     rsp_data, lb_addr, lb_wr_data, stray_cnt);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        #3;
        check_all_zero("reset_values");
        tick();
        tick();
        @(negedge clk);
        sys_rst = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_ready();
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = a;
        req_data  = d;
        exp_q.push_back('{err: 1'b0, data: '0});
        tick();                     // cycle N+1
        req_valid = 1'b0;
        checks++;
        if (lb_wr_en !== 1'b1 || lb_addr !== a || lb_wr_data !== d || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_strobe: we=%b a=%h wd=%h rv=%b rdy=%b, required we=1 a=%h wd=%h rv=0 rdy=0",
                     lb_wr_en, lb_addr, lb_wr_data, rsp_valid, req_ready, a, d);
        end
        tick();                     // cycle N+2
        checks++;
        if (lb_wr_en !== 1'b0 || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_rsp_timing: we=%b rv=%b rdy=%b, required we=0 rv=1 rdy=0",
                     lb_wr_en, rsp_valid, req_ready);
        end
        tick();                     // cycle N+3
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_ready_back: rdy=%b rv=%b, required rdy=1 rv=0", req_ready, rsp_valid);
        end
    endtask

    // k: cycle offset of the slave valid after lb_rd_en (0 = none).
    // exp_lat: cycles from lb_rd_en to rsp_valid.
    task automatic do_read(input logic [AW-1:0] a, input int k, input logic [DW-1:0] d,
                           input logic exp_err, input logic [DW-1:0] exp_data, input int exp_lat);
        int lat = -1;
        wait_ready();
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = a;
        req_data  = 32'h5555_AAAA;
        exp_q.push_back('{err: exp_err, data: exp_data});
        tick();
        req_valid = 1'b0;
        checks++;
        if (lb_rd_en !== 1'b1 || lb_wr_en !== 1'b0 || lb_addr !== a) begin
            errors++;
            $display("FAIL rd_strobe: rde=%b we=%b a=%h, required rde=1 we=0 a=%h", lb_rd_en, lb_wr_en, lb_addr, a);
        end
        for (int c = 1; c <= TO + 4; c++) begin
            tick();
            if (rsp_valid && lat < 0) lat = c;
            lb_rd_valid = (c == k);
            lb_rd_data  = (c == k) ? d : 32'h0BAD_0BAD;
        end
        lb_rd_valid = 1'b0;
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL rd_latency: k=%0d got %0d cycles, required %0d", k, lat, exp_lat);
        end
    endtask

    task automatic test_read();
        do_read(12'h044, 3, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 4);
        do_read(12'h045, 1, 32'h0000_0001, 1'b0, 32'h0000_0001, 2);
    endtask

    task automatic test_timeout();
        do_read(12'h100, 0, '0, 1'b1, 32'hDEAD_BEEF, TO + 1);
    endtask

    task automatic test_timeout_edge();
        do_read(12'h101, TO, 32'h7777_1111, 1'b0, 32'h7777_1111, TO + 1);
        checks++;
        if (stray_cnt !== 8'd0) begin
            errors++;
            $display("FAIL edge_no_stray: stray_cnt=%0d, required 0", stray_cnt);
        end
        do_read(12'h102, TO + 1, 32'h8888_2222, 1'b1, 32'hDEAD_BEEF, TO + 1);
        checks++;
        if (stray_cnt !== 8'd1) begin
            errors++;
            $display("FAIL late_stray: stray_cnt=%0d, required 1", stray_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat = '0;
        wait_ready();
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 12'h0A1;
        req_data  = 32'h1111_0001;
        exp_q.push_back('{err: 1'b0, data: '0});
        exp_q.push_back('{err: 1'b0, data: '0});
        for (int c = 0; c < 6; c++) begin
            tick();
            pat[c] = lb_wr_en;
            if (c == 0) begin
                req_addr = 12'h0A2;
                req_data = 32'h2222_0002;
            end
            if (c == 3) begin
                req_valid = 1'b0;
                checks++;
                if (lb_addr !== 12'h0A2 || lb_wr_data !== 32'h2222_0002) begin
                    errors++;
                    $display("FAIL b2b_second: a=%h wd=%h, required a=0a2 wd=22220002", lb_addr, lb_wr_data);
                end
            end
        end
        checks++;
        if (pat !== 6'b001001) begin
            errors++;
            $display("FAIL b2b_pattern: wr_en pattern=%b, required 001001", pat);
        end
    endtask

    task automatic test_strays();
        for (int i = 0; i < 300; i++) begin
            lb_rd_valid = 1'b1;
            tick();
            lb_rd_valid = 1'b0;
            tick();
        end
        checks++;
        if (stray_cnt !== 8'd255) begin
            errors++;
            $display("FAIL stray_sat: stray_cnt=%0d, required 255", stray_cnt);
        end
        do_read(12'h0C0, 2, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 3);
        checks++;
        if (stray_cnt !== 8'd255) begin
            errors++;
            $display("FAIL stray_hold: stray_cnt=%0d, required 255", stray_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        int rv_seen = 0;
        wait_ready();
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 12'h0AB;
        tick();                     // RD
        req_valid = 1'b0;
        tick();                     // RD_WAIT
        tick();
        sys_rst = 1'b0;
        #2;
        check_all_zero("mid_read_reset");
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid) rv_seen++;
        end
        @(negedge clk);
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid) rv_seen++;
        end
        checks++;
        if (rv_seen != 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_rsp: rsp_valid cycles=%0d rdy=%b, required 0 and rdy=1", rv_seen, req_ready);
        end
        test_write(12'h020, 32'hA5A5_5A5A);
    endtask

    initial begin
        test_reset();
        test_write(12'h010, 32'h1234_5678);
        test_read();
        test_timeout();
        test_timeout_edge();
        test_back_to_back();
        test_strays();
        test_reset_mid_read();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_rsp: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
